// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle between an upstream controller and serial_adder_ctrl.
// The master drives the operands and start; the slave returns status and the registered result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB first over WIDTH cycles,
// with a start/busy/done handshake and registered sum/carry-out.
module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module full_adder_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s0, c0, c1;

    half_adder u_ha0 (.x_i(x_i), .y_i(y_i), .s_o(s0),  .c_o(c0));
    half_adder u_ha1 (.x_i(s0),  .y_i(c_i), .s_o(s_o), .c_o(c1));

    assign c_o = c0 | c1;
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one sum bit produced per cycle, LSB first
// DONE  | result registers just updated; done pulses for one cycle
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;

    logic             fa_s, fa_c;
    logic [WIDTH-1:0] acc_shift;

    full_adder_cell u_fa (
        .x_i(a_sh_q[0]),
        .y_i(b_sh_q[0]),
        .c_i(carry_q),
        .s_o(fa_s),
        .c_o(fa_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_shift = fa_s;
        end else begin : g_acc_wn
            assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.c_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = acc_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = acc_shift;
                    c_out_d = fa_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus random vectors
// compared against plain a+b+c_in arithmetic and the WIDTH+2 cycle handshake rhythm.
module tb_serial_adder_ctrl;
    localparam int W      = 8;
    localparam int PERIOD = W + 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    serial_adder_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one addition and measures the handshake; performs no checks itself.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W:0] res, output int busy_cycles,
                          output logic done_seen, output logic busy_at_done);
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.c_in  = cin;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        busy_cycles = 0;
        while (bus_if.busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            tick();
        end
        done_seen    = bus_if.done;
        busy_at_done = bus_if.busy;
        res          = {bus_if.c_out, bus_if.sum};
        tick();
    endtask

    task automatic test_reset();
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.c_in  = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        n_cmp++;
        if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
        n_cmp++;
        if ({bus_if.c_out, bus_if.sum} !== 9'h000) begin
            n_fail++; $display("FAIL reset_result: got %h want 000", {bus_if.c_out, bus_if.sum});
        end
        repeat (5) tick();
        n_cmp++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_hold: busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_basic();
        logic [W:0] res;
        int         bc;
        logic       dn, bz;
        do_add(8'h0F, 8'h01, 1'b0, res, bc, dn, bz);
        n_cmp++;
        if (bc !== W) begin n_fail++; $display("FAIL basic_busy_len: got %0d want %0d", bc, W); end
        n_cmp++;
        if (dn !== 1'b1 || bz !== 1'b0) begin n_fail++; $display("FAIL basic_done: done=%b busy=%b want 1 0", dn, bz); end
        n_cmp++;
        if (res !== 9'h010) begin n_fail++; $display("FAIL basic_result: got %h want 010", res); end
        n_cmp++;
        if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", bus_if.done); end
    endtask

    task automatic test_carry();
        logic [W:0] res;
        int         bc;
        logic       dn, bz;
        do_add(8'hFF, 8'h01, 1'b0, res, bc, dn, bz);
        n_cmp++;
        if (res !== 9'h100) begin n_fail++; $display("FAIL carry_ripple: got %h want 100", res); end
        do_add(8'hFF, 8'hFF, 1'b1, res, bc, dn, bz);
        n_cmp++;
        if (res !== 9'h1FF) begin n_fail++; $display("FAIL carry_full: got %h want 1ff", res); end
    endtask

    task automatic test_ignored_start();
        int         dones;
        int         busy_after;
        logic [W:0] got;
        logic       held_ok;
        logic       finished;
        dones      = 0;
        busy_after = 0;
        got        = '0;
        held_ok    = 1'b1;
        finished   = 1'b0;
        bus_if.a     = 8'h12;
        bus_if.b     = 8'h34;
        bus_if.c_in  = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (i == 2) begin
                bus_if.a     = 8'hAA;
                bus_if.b     = 8'h55;
                bus_if.start = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end
            if (bus_if.done === 1'b1) begin
                dones++;
                got      = {bus_if.c_out, bus_if.sum};
                finished = 1'b1;
            end else if (!finished && {bus_if.c_out, bus_if.sum} !== 9'h1FF) begin
                held_ok = 1'b0;
            end
            if (finished && bus_if.busy === 1'b1) busy_after++;
            tick();
        end
        n_cmp++;
        if (dones !== 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", dones); end
        n_cmp++;
        if (got !== 9'h046) begin n_fail++; $display("FAIL ignored_result: got %h want 046", got); end
        n_cmp++;
        if (held_ok !== 1'b1) begin n_fail++; $display("FAIL ignored_sum_hold: got %b want 1", held_ok); end
        n_cmp++;
        if (busy_after !== 0) begin n_fail++; $display("FAIL ignored_not_queued: got %0d want 0", busy_after); end
    endtask

    task automatic test_reset_midop();
        logic [W:0] res;
        int         bc;
        logic       dn, bz;
        int         dones;
        dones = 0;
        bus_if.a     = 8'h80;
        bus_if.b     = 8'h80;
        bus_if.c_in  = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_status: busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
        end
        n_cmp++;
        if ({bus_if.c_out, bus_if.sum} !== 9'h000) begin
            n_fail++; $display("FAIL midrst_result: got %h want 000", {bus_if.c_out, bus_if.sum});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < PERIOD; i++) begin
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) dones++;
            tick();
        end
        n_cmp++;
        if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
        do_add(8'h80, 8'h80, 1'b0, res, bc, dn, bz);
        n_cmp++;
        if (res !== 9'h100 || dn !== 1'b1) begin
            n_fail++; $display("FAIL midrst_restart: got %h done=%b want 100 1", res, dn);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] ops[$];
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   expv;
        logic         exp_done;
        ops.delete();
        for (int n = 0; n < 5 * PERIOD; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            bus_if.a     = ra;
            bus_if.b     = rb;
            bus_if.c_in  = rc;
            bus_if.start = 1'b1;
            ops.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
            tick();
            exp_done = (n % PERIOD) == (W);
            n_cmp++;
            if (bus_if.done !== exp_done) begin
                n_fail++; $display("FAIL b2b_done_edge%0d: got %b want %b", n, bus_if.done, exp_done);
            end
            if (exp_done) begin
                expv = ops[n - W];
                n_cmp++;
                if ({bus_if.c_out, bus_if.sum} !== expv) begin
                    n_fail++; $display("FAIL b2b_result_edge%0d: got %h want %h", n, {bus_if.c_out, bus_if.sum}, expv);
                end
            end
        end
        bus_if.start = 1'b0;
        repeat (PERIOD) tick();
    endtask

    task automatic test_random();
        logic [W:0]   res;
        logic [W:0]   expv;
        logic [W-1:0] ra, rb;
        logic         rc;
        int           bc;
        logic         dn, bz;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            expv = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_add(ra, rb, rc, res, bc, dn, bz);
            n_cmp++;
            if (res !== expv || dn !== 1'b1 || bc !== W) begin
                n_fail++;
                $display("FAIL random_%0d: %h+%h+%b got %h done=%b busy_len=%0d want %h 1 %0d",
                         i, ra, rb, rc, res, dn, bc, expv, W);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.c_in  = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition bit-serially by reusing one 1-bit full-adder cell, LSB first, over WIDTH clock cycles. It is the area-minimal alternative to the ripple-carry adder in the adder library. It provides a start/busy/done interface so an upstream controller can issue additions and collect registered results. The full-adder cell is built from two half-adder instances plus an OR gate for carry-out.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request a new addition; sampled only in IDLE
a      input   WIDTH  operand A; captured on the accepting edge
b      input   WIDTH  operand B; captured on the accepting edge
c_in   input   1      carry-in; captured on the accepting edge
busy   output  1      high while an addition is in progress (RUN state)
done   output  1      one-cycle pulse: result registers were just updated
sum    output  WIDTH  registered sum of the last completed addition
c_out  output  1      registered carry-out of the last completed addition

Behaviour:
- Decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy=0; done=0; sum=0; c_out=0; all internal shift registers, carry flop and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - a_sh<=a, b_sh<=b, carry<=c_in, acc<=0, cnt<=0.
  - Next state RUN.
  - start=0 keeps the FSM in IDLE.
- RUN, one bit per edge:
  - fa_s = a_sh[0]^b_sh[0]^carry; fa_c is the majority of the same three bits.
  - a_sh and b_sh shift right by 1.
  - acc <= {fa_s, acc[WIDTH-1:1]}; carry <= fa_c; cnt <= cnt+1.
- RUN to DONE: on the edge where cnt==WIDTH-1, which is edge E_WIDTH. On that same edge sum <= final acc (including the last fa_s) and c_out <= final fa_c.
- DONE: done=1 and busy=0 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: start accepted at E0; busy high after E0 through E_WIDTH; done high during the cycle after E_WIDTH.
- Throughput: one addition every WIDTH+2 cycles when start is held high.
- busy and done are decoded from state only, and are never high together.
- sum and c_out hold their values until the next completion. They do not change during RUN or on start.
- Counter width is clog2(WIDTH), minimum 1. When WIDTH=1, RUN lasts exactly one cycle.
- start in RUN or DONE is ignored and is not queued. Operand changes during RUN have no effect.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); there is never overflow loss.
- Reset mid-operation: all state clears immediately and asynchronously. sum and c_out return to 0, no done pulse is produced, and the next start is accepted normally after rst_n rises.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> busy=0, done=0, sum=8'h00, c_out=0; FSM stays IDLE with start=0.
- Basic add: a=8'h0F, b=8'h01, c_in=0, start pulse at E0 -> busy high for 8 cycles; done pulse one cycle after E8; sum=8'h10, c_out=0.
- Carry ripple: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Then a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
- Ignored start: during RUN of 8'h12+8'h34, pulse start with a=8'hAA, b=8'h55 -> result 8'h46, c_out=0; exactly one done pulse; sum holds its old value until done.
- Reset mid-op: assert rst_n=0 after E4 of 8'h80+8'h80 -> sum=0, c_out=0, busy=0 immediately, no done. After release, 8'h80+8'h80 -> sum=8'h00, c_out=1.
- Back-to-back: hold start=1 with changing operands, WIDTH=8 -> done pulses every 10 cycles; each result matches the operands present at its accepting edge; also run a random compare of 200 vectors against a+b+c_in.
